// File: rtl/room_model_pkg.sv
// Shared definitions for the room thermal plant: state encoding,
// default temperature width and the actuator-command decoder.
package room_model_pkg;

  localparam int P_TEMP_WIDTH = 5;

  typedef enum logic [1:0] {
    S_DRIFT = 2'd0,
    S_HEAT  = 2'd1,
    S_COOL  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Maps the {heating, cooling} command pair onto the plant mode.
  function automatic state_t decode_mode(input logic heat, input logic cool);
    state_t mode;
    case ({heat, cool})
      2'b10:   mode = S_HEAT;
      2'b01:   mode = S_COOL;
      2'b11:   mode = S_FAULT;
      default: mode = S_DRIFT;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/room_temp_model_rate_divider.sv
// Rate divider: counts cycles spent in one plant mode and fires a tick
// on the cycle where the count reaches the terminal value i_term.
// i_clear restarts the count and suppresses the tick.
module rate_divider #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = !i_clear && (r_cnt == i_term);

  // Count up, wrapping to zero on the terminal tick or on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/room_temp_model.sv
// Synthesisable thermal plant: integrates heater/cooler commands into
// saturating 1-degree steps, drifts toward ambient when idle, latches a
// sticky fault when both actuators are commanded, and pulses
// temp_changed whenever the registered temperature moves.
module room_temp_model
  import room_model_pkg::*;
#(
  parameter int TEMP_WIDTH = P_TEMP_WIDTH,
  parameter int INIT_TEMP  = 20,
  parameter int AMBIENT    = 18,
  parameter int HEAT_DIV   = 4,
  parameter int COOL_DIV   = 4,
  parameter int DRIFT_DIV  = 16,
  parameter int TEMP_MIN   = 0,
  parameter int TEMP_MAX   = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  heating,
  input  logic                  cooling,
  input  logic                  load,
  input  logic [TEMP_WIDTH-1:0] load_value,
  output logic [TEMP_WIDTH-1:0] temperature,
  output logic                  temp_changed,
  output logic                  fault
);

  // Counter must hold the largest DIV-1 of the three modes.
  localparam int MAX_DIV_HC = (HEAT_DIV > COOL_DIV) ? HEAT_DIV : COOL_DIV;
  localparam int MAX_DIV    = (MAX_DIV_HC > DRIFT_DIV) ? MAX_DIV_HC : DRIFT_DIV;
  localparam int CNT_W      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  // Bounds widened by one bit so +1 never wraps before it is compared.
  localparam logic [TEMP_WIDTH:0]   C_MIN  = (TEMP_WIDTH+1)'(TEMP_MIN);
  localparam logic [TEMP_WIDTH:0]   C_MAX  = (TEMP_WIDTH+1)'(TEMP_MAX);
  localparam logic [TEMP_WIDTH:0]   C_AMB  = (TEMP_WIDTH+1)'(AMBIENT);
  localparam logic [TEMP_WIDTH-1:0] C_MIN_T  = TEMP_WIDTH'(TEMP_MIN);
  localparam logic [TEMP_WIDTH-1:0] C_MAX_T  = TEMP_WIDTH'(TEMP_MAX);
  localparam logic [TEMP_WIDTH-1:0] C_INIT_T = TEMP_WIDTH'(INIT_TEMP);

  state_t                  r_state;
  state_t                  w_state_next;
  state_t                  w_mode;
  logic [TEMP_WIDTH-1:0]   r_temp;
  logic [TEMP_WIDTH-1:0]   w_temp_next;
  logic [TEMP_WIDTH-1:0]   w_step_val;
  logic [TEMP_WIDTH-1:0]   w_load_val;
  logic [TEMP_WIDTH-1:0]   w_dn;
  logic [TEMP_WIDTH:0]     w_ext;
  logic [TEMP_WIDTH:0]     w_up;
  logic [TEMP_WIDTH:0]     w_load_ext;
  logic                    r_fault;
  logic                    w_fault_next;
  logic                    r_changed;
  logic                    w_clear;
  logic                    w_tick;
  logic [CNT_W-1:0]        w_term;

  assign w_mode       = decode_mode(heating, cooling);
  assign temperature  = r_temp;
  assign temp_changed = r_changed;
  assign fault        = r_fault;

  // Progress is discarded on load, while latched in fault, and on any
  // mode change, so the first step always lands DIV edges after entry.
  assign w_clear = load || (r_state == S_FAULT) || (w_mode != r_state);

  // Terminal count for the mode currently being integrated.
  always_comb begin
    w_term = '0;
    case (r_state)
      S_HEAT:  w_term = CNT_W'(HEAT_DIV - 1);
      S_COOL:  w_term = CNT_W'(COOL_DIV - 1);
      S_DRIFT: w_term = CNT_W'(DRIFT_DIV - 1);
      default: w_term = '0;
    endcase
  end

  rate_divider #(
    .CNT_W (CNT_W)
  ) u_rate_divider (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_term  (w_term),
    .o_tick  (w_tick)
  );

  assign w_ext      = {1'b0, r_temp};
  assign w_up       = w_ext + 1'b1;
  // Only used when r_temp is strictly above a bound >= 0, so no wrap.
  assign w_dn       = r_temp - 1'b1;
  assign w_load_ext = {1'b0, load_value};

  // Saturating step value for the current mode.
  always_comb begin
    w_step_val = r_temp;
    case (r_state)
      S_HEAT:  w_step_val = (w_up > C_MAX) ? C_MAX_T : w_up[TEMP_WIDTH-1:0];
      S_COOL:  w_step_val = (w_ext > C_MIN) ? w_dn : C_MIN_T;
      S_DRIFT: begin
        if (w_ext < C_AMB) begin
          w_step_val = w_up[TEMP_WIDTH-1:0];
        end else if (w_ext > C_AMB) begin
          w_step_val = w_dn;
        end
      end
      default: w_step_val = r_temp;
    endcase
  end

  // Load value clamped into the legal temperature range.
  always_comb begin
    w_load_val = load_value;
    if (w_load_ext < C_MIN) begin
      w_load_val = C_MIN_T;
    end else if (w_load_ext > C_MAX) begin
      w_load_val = C_MAX_T;
    end
  end

  // Next state, fault and temperature; load overrides everything and
  // S_FAULT ignores the commands until a load arrives.
  always_comb begin
    w_state_next = r_state;
    w_fault_next = r_fault;
    w_temp_next  = r_temp;
    if (load) begin
      w_state_next = w_mode;
      w_fault_next = (w_mode == S_FAULT);
      w_temp_next  = w_load_val;
    end else if (r_state != S_FAULT) begin
      w_state_next = w_mode;
      if (w_mode == S_FAULT) begin
        w_fault_next = 1'b1;
      end
      if (w_tick) begin
        w_temp_next = w_step_val;
      end
    end
  end

  // State, temperature, fault and change-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_DRIFT;
      r_temp    <= C_INIT_T;
      r_fault   <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_temp    <= w_temp_next;
      r_fault   <= w_fault_next;
      r_changed <= (w_temp_next != r_temp);
    end
  end

endmodule

// File: tb/tb_room_temp_model.sv
// Self-checking bench for room_temp_model: directed scenarios followed
// by randomized commands, compared every edge against a behavioural
// model that counts edges spent in each mode.
module tb_room_temp_model;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       heating;
  logic       cooling;
  logic       load;
  logic [4:0] load_value;
  logic [4:0] temperature;
  logic       temp_changed;
  logic       fault;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: mode 0=drift 1=heat 2=cool 3=fault; age = edges spent in mode.
  int m_temp;
  int m_mode;
  int m_age;
  int m_fault;
  int m_changed;

  always #5 clk = ~clk;

  room_temp_model dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .heating      (heating),
    .cooling      (cooling),
    .load         (load),
    .load_value   (load_value),
    .temperature  (temperature),
    .temp_changed (temp_changed),
    .fault        (fault)
  );

  function automatic int decode(input logic h, input logic c);
    if (h && c) return 3;
    if (h)      return 1;
    if (c)      return 2;
    return 0;
  endfunction

  function automatic int div_of(input int mode);
    if (mode == 1) return 4;
    if (mode == 2) return 4;
    return 16;
  endfunction

  function automatic int stepped(input int mode, input int t);
    if (mode == 1) return (t < 31) ? t + 1 : 31;
    if (mode == 2) return (t > 0) ? t - 1 : 0;
    if (t < 18) return t + 1;
    if (t > 18) return t - 1;
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_temp = 20; m_mode = 0; m_age = 0; m_fault = 0; m_changed = 0;
  endtask

  task automatic model_edge();
    int old_t;
    int nm;
    old_t = m_temp;
    nm = decode(heating, cooling);
    if (load) begin
      m_temp  = (int'(load_value) > 31) ? 31 : int'(load_value);
      m_mode  = nm;
      m_age   = 0;
      m_fault = (nm == 3) ? 1 : 0;
    end else if (m_mode != 3) begin
      if (nm != m_mode) begin
        m_mode = nm;
        m_age  = 0;
        if (nm == 3) m_fault = 1;
      end else begin
        m_age++;
        if (m_age % div_of(m_mode) == 0) m_temp = stepped(m_mode, m_temp);
      end
    end
    m_changed = (m_temp != old_t) ? 1 : 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".temp"},    32'(temperature),  32'(m_temp));
    check({tag, ".changed"}, 32'(temp_changed), 32'(m_changed));
    check({tag, ".fault"},   32'(fault),        32'(m_fault));
  endtask

  // One clock edge with the given commands, then compare against the model.
  task automatic cycle(input logic h, input logic c, input logic ld, input logic [4:0] v,
                       input string tag);
    heating = h; cooling = c; load = ld; load_value = v;
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
    $display("t=%0t %s h=%0b c=%0b ld=%0b v=%0d -> temp=%0d chg=%0b fault=%0b",
             $time, tag, h, c, ld, v, temperature, temp_changed, fault);
  endtask

  initial begin
    int r;
    logic [1:0] rmode;
    logic rh, rc, rl;
    logic [4:0] rv;

    heating = 1'b0; cooling = 1'b0; load = 1'b0; load_value = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("reset.temp",    32'(temperature),  32'd20);
    check("reset.fault",   32'(fault),        32'd0);
    check("reset.changed", 32'(temp_changed), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold.temp", 32'(temperature), 32'd20);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 5'd0, "post_reset");
    check("post_reset.const", 32'(temperature), 32'd20);

    // Heating from edge 0: steps at edges 4, 8, 12.
    for (int i = 0; i <= 12; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 5'd0, "heat");
      if (i == 4 || i == 8 || i == 12) begin
        check("heat.step_value", 32'(temperature), 32'(20 + i / 4));
      end
      check("heat.pulse", 32'(temp_changed), (i > 0 && i % 4 == 0) ? 32'd1 : 32'd0);
    end

    // Load 1 then cool: reaches 0 at edge 4 and saturates there.
    cycle(1'b0, 1'b0, 1'b1, 5'd1, "load1");
    check("load1.temp", 32'(temperature), 32'd1);
    for (int j = 0; j < 12; j++) begin
      cycle(1'b0, 1'b1, 1'b0, 5'd0, "cool_sat");
      if (j >= 4) check("cool_sat.floor", 32'(temperature), 32'd0);
      check("cool_sat.pulse", 32'(temp_changed), (j == 4) ? 32'd1 : 32'd0);
    end

    // Load 25 and let it drift toward ambient 18.
    cycle(1'b0, 1'b0, 1'b1, 5'd25, "load25");
    for (int k = 1; k <= 140; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 5'd0, "drift");
      if (k == 16) check("drift.edge16", 32'(temperature), 32'd24);
      if (k == 32) check("drift.edge32", 32'(temperature), 32'd23);
    end
    check("drift.settled", 32'(temperature), 32'd18);
    check("drift.quiet",   32'(temp_changed), 32'd0);

    // Both actuators: fault latches and temperature freezes.
    cycle(1'b1, 1'b1, 1'b0, 5'd0, "fault_set");
    check("fault_set.flag", 32'(fault), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 5'd0, "fault_hold");
      check("fault_hold.temp", 32'(temperature), 32'd18);
    end
    cycle(1'b1, 1'b0, 1'b1, 5'd20, "fault_clear");
    check("fault_clear.flag", 32'(fault), 32'd0);
    check("fault_clear.temp", 32'(temperature), 32'd20);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 5'd0, "resume");
      if (i == 3) check("resume.first", 32'(temperature), 32'd21);
      if (i == 7) check("resume.second", 32'(temperature), 32'd22);
    end

    // Heat->cool switch at cnt=2: no step, first -1 four edges later.
    cycle(1'b1, 1'b0, 1'b1, 5'd10, "sw_load");
    cycle(1'b1, 1'b0, 1'b0, 5'd0, "sw_heat");
    cycle(1'b1, 1'b0, 1'b0, 5'd0, "sw_heat");
    for (int m = 0; m <= 4; m++) begin
      cycle(1'b0, 1'b1, 1'b0, 5'd0, "sw_cool");
      check("sw_cool.value", 32'(temperature), (m == 4) ? 32'd9 : 32'd10);
    end

    // Asynchronous reset mid-cycle takes effect before the next edge.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.temp",    32'(temperature),  32'd20);
    check("async_rst.changed", 32'(temp_changed), 32'd0);
    check("async_rst.fault",   32'(fault),        32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 5'd20, "load_equal");
    check("load_equal.pulse", 32'(temp_changed), 32'd0);

    // Randomized commands with occasional loads.
    rmode = 2'd0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 15);
        rmode = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      end
      rh = rmode[0] | (rmode == 2'd3);
      rc = rmode[1];
      rl = ($urandom_range(0, 19) == 0);
      rv = 5'($urandom_range(0, 31));
      if (rl && rh && rc) rc = 1'b0;
      cycle(rh, rc, rl, rv, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
